noc_flit_input_buffer: RTL and testbench



---
 rtl/noc_flit_input_buffer_pkg.sv | 8 +
 rtl/noc_flit_fifo_mem.sv | 17 +
 rtl/noc_flit_input_buffer.sv | 77 +++++++
 tb/tb_noc_flit_input_buffer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/noc_flit_input_buffer_pkg.sv
// noc_flit_input_buffer_pkg: shared NoC flit width, input-buffer depth, tag bit offsets and framing states
package noc_flit_input_buffer_pkg;
  localparam int NOC_DATA_WIDTH = 32;
  localparam int NOC_INBUF_DEPTH = 4;
  localparam int TAG_TAIL_OFS = 0;
  localparam int TAG_HDR_OFS = 1;
  typedef enum logic {EXPECT_HDR, IN_PKT} frame_state_e;
endpackage

// File: rtl/noc_flit_fifo_mem.sv
// noc_flit_fifo_mem: DEPTH x W register array, clk/we/waddr/wdata write port, raddr/rdata asynchronous read port
module noc_flit_fifo_mem #(
  parameter int W = 34,
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [W-1:0]     rdata
);
  logic [W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we) mem_q[waddr] <= wdata;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/noc_flit_input_buffer.sv
// noc_flit_input_buffer: FWFT router input flit FIFO (in_* valid/ready push, out_* valid/ready pop) with flit/packet counts and sticky framing_err
module noc_flit_input_buffer
  import noc_flit_input_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int DEPTH = NOC_INBUF_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_flit,
  input  logic                  in_is_header,
  input  logic                  in_is_tail,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_flit,
  output logic                  out_is_header,
  output logic                  out_is_tail,
  output logic [PTR_W:0]        count,
  output logic [PTR_W:0]        pkt_count,
  output logic                  framing_err,
  input  logic                  err_clear
);
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d, pkt_count_q, pkt_count_d;
  logic err_q, err_d, push, pop, set_err;
  frame_state_e state_q, state_d;
  logic [DATA_WIDTH+1:0] rdata;
  assign in_ready = count_q != (PTR_W+1)'(DEPTH);
  assign out_valid = count_q != '0;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_flit = rdata[DATA_WIDTH-1:0];
  assign out_is_header = rdata[DATA_WIDTH+TAG_HDR_OFS];
  assign out_is_tail = rdata[DATA_WIDTH+TAG_TAIL_OFS];
  assign count = count_q;
  assign pkt_count = pkt_count_q;
  assign framing_err = err_q;
  noc_flit_fifo_mem #(.W(DATA_WIDTH+2), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
    .clk(noc_clk),
    .we(push),
    .waddr(wr_ptr_q),
    .wdata({in_is_header, in_is_tail, in_flit}),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    pkt_count_d = pkt_count_q + (PTR_W+1)'(push & in_is_tail) - (PTR_W+1)'(pop & out_is_tail);
    set_err = push & ((state_q == EXPECT_HDR) ? !in_is_header : in_is_header);
    state_d = !push ? state_q :
              in_is_header ? (in_is_tail ? EXPECT_HDR : IN_PKT) :
              (state_q == IN_PKT && !in_is_tail) ? IN_PKT : EXPECT_HDR;
    err_d = set_err | (err_q & !err_clear);
  end
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      pkt_count_q <= '0;
      state_q <= EXPECT_HDR;
      err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      pkt_count_q <= pkt_count_d;
      state_q <= state_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_noc_flit_input_buffer.sv
// tb_noc_flit_input_buffer: directed stimulus with expected-flit scoreboard and separate output monitor
module tb_noc_flit_input_buffer;
  logic noc_clk, noc_rst_n, in_valid, in_ready, in_is_header, in_is_tail;
  logic out_valid, out_ready, out_is_header, out_is_tail, framing_err, err_clear;
  logic [31:0] in_flit, out_flit;
  logic [2:0] count, pkt_count;
  logic [33:0] sb[$];
  int n_cmp = 0, n_bad = 0;
  logic acc, tog;
  noc_flit_input_buffer dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
    .in_is_header(in_is_header), .in_is_tail(in_is_tail),
    .out_valid(out_valid), .out_ready(out_ready), .out_flit(out_flit),
    .out_is_header(out_is_header), .out_is_tail(out_is_tail),
    .count(count), .pkt_count(pkt_count),
    .framing_err(framing_err), .err_clear(err_clear)
  );
  initial noc_clk = 1'b0;
  always #5 noc_clk = ~noc_clk;
  always @(negedge noc_clk) begin
    if (noc_rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_flit: got %h with nothing expected", {out_is_header, out_is_tail, out_flit});
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        if ({out_is_header, out_is_tail, out_flit} !== e) begin
          n_bad++;
          $display("FAIL flit_order: got %h expected %h", {out_is_header, out_is_tail, out_flit}, e);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic h, input logic t, input logic [31:0] d,
                     input logic ordy, input logic clr, output logic a);
    in_valid = v; in_is_header = h; in_is_tail = t; in_flit = d;
    out_ready = ordy; err_clear = clr;
    @(negedge noc_clk);
    a = v && in_ready;
    if (a) sb.push_back({h, t, d});
    @(posedge noc_clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; err_clear = 1'b0;
  endtask
  initial begin
    noc_rst_n = 1'b0; in_valid = 1'b0; in_is_header = 1'b0; in_is_tail = 1'b0;
    in_flit = '0; out_ready = 1'b0; err_clear = 1'b0; tog = 1'b1;
    repeat (3) @(posedge noc_clk);
    #1 noc_rst_n = 1'b1;
    @(posedge noc_clk); #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_pkt_count", 32'(pkt_count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_framing_err", 32'(framing_err), 0);
    cyc(1, 1, 0, 32'hA0000001, 1, 0, acc);
    chk("pkt_hdr_visible", 32'(out_valid), 1);
    cyc(1, 0, 0, 32'hFF000002, 1, 0, acc);
    cyc(1, 0, 1, 32'hB0000003, 1, 0, acc);
    chk("pkt_count_tail_push", 32'(pkt_count), 1);
    chk("count_stream", 32'(count), 1);
    cyc(0, 0, 0, 0, 1, 0, acc);
    chk("pkt_count_tail_pop", 32'(pkt_count), 0);
    chk("count_drained", 32'(count), 0);
    chk("pkt_framing_ok", 32'(framing_err), 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 32'h10 + i, 0, 0, acc);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_pkt_count", 32'(pkt_count), 4);
    cyc(1, 1, 1, 32'h14, 0, 0, acc);
    chk("full_refuse", 32'(count), 4);
    cyc(0, 0, 0, 0, 1, 0, acc);
    chk("pop_one_count", 32'(count), 3);
    chk("pop_one_in_ready", 32'(in_ready), 1);
    cyc(1, 1, 1, 32'h15, 0, 0, acc);
    chk("refill_count", 32'(count), 4);
    cyc(1, 1, 1, 32'h16, 1, 0, acc);
    chk("full_pop_no_push", 32'(count), 3);
    cyc(1, 1, 1, 32'h17, 1, 0, acc);
    chk("push_pop_hold", 32'(count), 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0, acc);
    chk("drain_count", 32'(count), 0);
    chk("drain_pkt_count", 32'(pkt_count), 0);
    for (int i = 0; i < 10; i++) begin
      acc = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
        cyc(1, 1, 1, 32'h50 + i, tog, 0, acc);
        tog = !tog;
      end
      if (!acc) chk("wrap_accept_timeout", 0, 1);
    end
    for (int k = 0; k < 20 && count != 0; k++) cyc(0, 0, 0, 0, 1, 0, acc);
    chk("wrap_count", 32'(count), 0);
    chk("wrap_pkt_count", 32'(pkt_count), 0);
    chk("wrap_sb_empty", 32'(sb.size()), 0);
    cyc(1, 0, 0, 32'hC1, 1, 0, acc);
    chk("orphan_body_err", 32'(framing_err), 1);
    cyc(0, 0, 0, 0, 1, 1, acc);
    chk("err_cleared", 32'(framing_err), 0);
    chk("orphan_emitted", 32'(count), 0);
    cyc(1, 1, 0, 32'hD1, 1, 0, acc);
    chk("hdr_ok", 32'(framing_err), 0);
    cyc(1, 1, 0, 32'hD2, 1, 0, acc);
    chk("hdr_hdr_err", 32'(framing_err), 1);
    cyc(1, 0, 1, 32'hD3, 1, 0, acc);
    cyc(0, 0, 0, 0, 1, 1, acc);
    chk("err_cleared2", 32'(framing_err), 0);
    cyc(1, 1, 0, 32'hE1, 0, 0, acc);
    cyc(1, 0, 0, 32'hE2, 0, 0, acc);
    chk("pre_rst_count", 32'(count), 2);
    #2 noc_rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_pkt_count", 32'(pkt_count), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    sb.delete();
    @(posedge noc_clk); #1 noc_rst_n = 1'b1;
    cyc(1, 0, 1, 32'hE3, 1, 0, acc);
    chk("post_rst_tail_err", 32'(framing_err), 1);
    chk("post_rst_pkt_count", 32'(pkt_count), 1);
    cyc(0, 0, 0, 0, 1, 0, acc);
    chk("final_count", 32'(count), 0);
    chk("final_pkt_count", 32'(pkt_count), 0);
    chk("final_sb_empty", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
